// File: rtl/flash_word_reader.sv
`default_nettype none
// ============================================================================
// Module   : flash_word_reader
// Purpose  : Issues one Avalon-MM flash read per start edge and returns the
//            word with a done pulse. A timeout aborts stalled transfers.
// Revision : 1.0 - initial release
// ============================================================================
module flash_word_reader #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_flag,
    input  logic [23:0]       addr,
    output logic [31:0]       data_in_read,
    output logic              done_read,
    output logic              read_error,
    output logic              busy,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [5:0]        flash_mem_burstcount,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Abort fires on the cycle whose increment would bring the count to TIMEOUT.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic       r_start_d;
    logic [7:0] r_cnt;
    logic       w_start_edge;
    logic       w_timeout;

    assign w_start_edge = start_flag & ~r_start_d;
    assign w_timeout    = (r_cnt == c_timeout_last);

    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_burstcount = 6'd1;

    generate
        if (ADDR_W < 24) begin : g_addr_trunc
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^addr[23:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_start_d         <= 1'b0;
            r_cnt             <= 8'd0;
            data_in_read      <= 32'h0;
            done_read         <= 1'b0;
            read_error        <= 1'b0;
            busy              <= 1'b0;
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
        end else begin
            r_start_d <= start_flag;
            done_read <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        flash_mem_address <= addr[ADDR_W-1:0];
                        read_error        <= 1'b0;
                        r_cnt             <= 8'd0;
                        flash_mem_read    <= 1'b1;
                        busy              <= 1'b1;
                        r_state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    // An acceptance on the final allowed cycle still loses to the abort.
                    if (w_timeout) begin
                        flash_mem_read <= 1'b0;
                        data_in_read   <= 32'h0;
                        read_error     <= 1'b1;
                        done_read      <= 1'b1;
                        r_state        <= S_DONE;
                    end else if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (flash_mem_readdatavalid) begin
                        data_in_read <= flash_mem_readdata;
                        done_read    <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        data_in_read <= 32'h0;
                        read_error   <= 1'b1;
                        done_read    <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_word_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_word_reader
// Purpose  : Directed self-checking bench for flash_word_reader (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_word_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_flag = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [31:0] data_in_read;
    logic        done_read;
    logic        read_error;
    logic        busy;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic [5:0]  flash_mem_burstcount;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = 32'h0;
    logic        flash_mem_readdatavalid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    flash_word_reader #(.ADDR_W(23), .TIMEOUT(8)) u_dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_flag              (start_flag),
        .addr                    (addr),
        .data_in_read            (data_in_read),
        .done_read               (done_read),
        .read_error              (read_error),
        .busy                    (busy),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"}, data_in_read, 32'h0);
        check({tag, "_done"}, {31'h0, done_read}, 32'h0);
        check({tag, "_err"},  {31'h0, read_error}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_rd"},   {31'h0, flash_mem_read}, 32'h0);
        check({tag, "_addr"}, {9'h0, flash_mem_address}, 32'h0);
    endtask

    // mode 0: single pulse; 1: second rising edge while busy; 2: start held high
    task automatic do_read(input logic [23:0] a, input int stall, input int lat,
                           input logic [31:0] d, input bit give_valid, input int mode,
                           output int done_cyc, output int nreads);
        logic [22:0] exp_addr;
        int req_seen;
        int acc_at;
        exp_addr = a[22:0];
        req_seen = 0;
        acc_at   = 0;
        done_cyc = -1;
        nreads   = 0;
        @(negedge clk);
        start_flag = 1'b1;
        addr       = a;
        flash_mem_waitrequest = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 && mode != 2) start_flag = 1'b0;
            if (c == 2 && mode == 1) start_flag = 1'b1;
            if (done_read) begin
                done_cyc = c;
                check("busy_at_done", {31'h0, busy}, 32'h1);
                break;
            end
            if (flash_mem_read) begin
                nreads++;
                req_seen++;
                check("req_addr", {9'h0, flash_mem_address}, {9'h0, exp_addr});
                flash_mem_waitrequest = (req_seen <= stall);
                if (!flash_mem_waitrequest) acc_at = c;
            end else begin
                flash_mem_waitrequest = 1'b0;
            end
            flash_mem_readdatavalid = give_valid && (acc_at > 0) && (c == acc_at + lat);
            flash_mem_readdata      = flash_mem_readdatavalid ? d : 32'hDEADBEEF;
        end
        flash_mem_readdatavalid = 1'b0;
        flash_mem_waitrequest   = 1'b0;
    endtask

    task automatic post_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("quiet_rd",   {31'h0, flash_mem_read}, 32'h0);
            check("quiet_done", {31'h0, done_read}, 32'h0);
        end
        check("quiet_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int dc;
        int nr;

        repeat (3) @(negedge clk);
        check_reset_state("rst");
        check("byteen", {28'h0, flash_mem_byteenable}, 32'hF);
        check("burst",  {26'h0, flash_mem_burstcount}, 32'h1);
        reset = 1'b0;

        // Basic read
        do_read(24'h000123, 0, 1, 32'hA1B2C3D4, 1'b1, 0, dc, nr);
        check("basic_lat",   dc, 3);
        check("basic_reads", nr, 1);
        check("basic_data",  data_in_read, 32'hA1B2C3D4);
        check("basic_err",   {31'h0, read_error}, 32'h0);
        post_quiet(3);

        // Stall 4 cycles, latency 3
        do_read(24'h3C0FF0, 4, 3, 32'h55AA1234, 1'b1, 0, dc, nr);
        check("stall_lat",   dc, 9);
        check("stall_reads", nr, 5);
        check("stall_data",  data_in_read, 32'h55AA1234);
        check("stall_err",   {31'h0, read_error}, 32'h0);
        post_quiet(2);

        // Timeout with no response, then a late response
        do_read(24'h000456, 0, 1, 32'h0, 1'b0, 0, dc, nr);
        check("to_lat",   dc, 9);
        check("to_reads", nr, 1);
        check("to_err",   {31'h0, read_error}, 32'h1);
        check("to_data",  data_in_read, 32'h0);
        @(negedge clk);
        @(negedge clk);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h12345678;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        check("late_data", data_in_read, 32'h0);
        check("late_done", {31'h0, done_read}, 32'h0);
        post_quiet(2);

        // Second edge while busy is dropped; start then held high after DONE
        do_read(24'h000777, 0, 1, 32'hCAFEF00D, 1'b1, 1, dc, nr);
        check("retrig_lat",   dc, 3);
        check("retrig_reads", nr, 1);
        check("retrig_err",   {31'h0, read_error}, 32'h0);
        check("retrig_data",  data_in_read, 32'hCAFEF00D);
        post_quiet(5);
        start_flag = 1'b0;

        // Start held high throughout
        do_read(24'h00BEEF, 1, 2, 32'h0BADF00D, 1'b1, 2, dc, nr);
        check("hold_lat",   dc, 5);
        check("hold_reads", nr, 2);
        check("hold_data",  data_in_read, 32'h0BADF00D);
        post_quiet(5);
        start_flag = 1'b0;

        // Reset during WAIT_DATA
        @(negedge clk);
        start_flag = 1'b1;
        addr       = 24'h0ABCDE;
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        start_flag = 1'b0;
        check("mid_rd", {31'h0, flash_mem_read}, 32'h1);
        @(negedge clk);
        check("mid_wait_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h87654321;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        check("midrst_ign_data", data_in_read, 32'h0);
        check("midrst_ign_done", {31'h0, done_read}, 32'h0);
        post_quiet(2);

        // Fresh read after reset, upper address bit discarded
        do_read(24'hFFFFFF, 0, 1, 32'hF00DFACE, 1'b1, 0, dc, nr);
        check("ff_lat",   dc, 3);
        check("ff_reads", nr, 1);
        check("ff_addr",  {9'h0, flash_mem_address}, 32'h007FFFFF);
        check("ff_data",  data_in_read, 32'hF00DFACE);
        post_quiet(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_word_reader.md
# flash_word_reader

Single-word read responder between the audio playback controller and the Avalon-MM flash controller. The playback controller raises a one-cycle read strobe with a 24-bit word address. This block issues one Avalon read, waits out `waitrequest` and read latency, and returns the 32-bit word with a one-cycle `done_read` pulse. A timeout keeps a stalled flash from hanging the speech datapath forever.

## Interface
Parameters:
- `ADDR_W`, default 23: flash word-address width driven to the flash controller.
- `TIMEOUT`, default 255: maximum cycles spent in REQ plus WAIT_DATA before abort; 8-bit counter, legal range 1–255.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset; one clock, with `reset` synchronous and active-high.
- `start_flag` in 1: read request from the playback controller; a rising edge triggers one read.
- `addr` in 24: word address, sampled on the accepted start edge.
- `data_in_read` out 32: last word returned; held until the next capture.
- `done_read` out 1: one-cycle pulse when `data_in_read` is valid.
- `read_error` out 1: set with `done_read` when the read timed out; cleared at the next accepted start.
- `busy` out 1: high in every state except IDLE.
- `flash_mem_read` out 1: Avalon read command.
- `flash_mem_address` out ADDR_W: `addr[ADDR_W-1:0]`, latched.
- `flash_mem_byteenable` out 4: constant 4'hF.
- `flash_mem_burstcount` out 6: constant 6'd1.
- `flash_mem_waitrequest` in 1: Avalon stall.
- `flash_mem_readdata` in 32: Avalon read data.
- `flash_mem_readdatavalid` in 1: Avalon data-valid qualifier.

## Operation
- Start edge: `start_flag & ~start_d`, where `start_d` is the registered `start_flag`.
  - It is honoured only in IDLE.
  - Edges in any other state are dropped, not queued.
- IDLE:
  - On an edge, latch `addr[ADDR_W-1:0]`, clear `read_error`, clear the timeout counter, and go to REQ.
  - Otherwise stay.
- REQ:
  - Drive `flash_mem_read=1` and hold `flash_mem_address` stable.
  - If `flash_mem_waitrequest=0` this cycle, the command is accepted; go to WAIT_DATA.
  - Otherwise stay.
- WAIT_DATA:
  - `flash_mem_read=0`.
  - On `flash_mem_readdatavalid=1`, capture `flash_mem_readdata` into `data_in_read` and go to DONE.
- DONE:
  - `done_read=1` for exactly this cycle, then go to IDLE.
- Timeout:
  - The counter increments every cycle in REQ and WAIT_DATA.
  - When it equals TIMEOUT and the transfer has not completed, go to DONE with `read_error=1` and `data_in_read=32'h0`.
  - `flash_mem_read` drops with the transition.
- `readdatavalid` seen in IDLE, REQ or DONE is ignored, including a late response after a timeout.
- Address width: upper `addr` bits above ADDR_W are discarded, with no range check.

## Timing
- Reset values:
  - `data_in_read=0`, `done_read=0`, `read_error=0`, `busy=0`, `flash_mem_read=0`, `flash_mem_address=0`.
  - `start_d=0`, counter=0, state=IDLE.
- Because reset clears `start_d`, a `start_flag` held high through reset counts as an edge in the first cycle after reset.
- Reset asserted in any state returns to IDLE on the next edge. Any outstanding Avalon read is abandoned and its data is ignored.
- Latency, with the start edge sampled at clock edge E:
  - `flash_mem_read` is high from E.
  - If `waitrequest=0` and `readdatavalid` is high in the following cycle, data is captured at E+2 and `done_read` is high for the cycle after E+2.
  - Minimum start-to-done is 3 cycles. Each `waitrequest` cycle and each extra latency cycle adds 1.
- `data_in_read` changes only on entry to DONE. It is stable whenever `done_read` is high and afterwards.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Basic read: `addr=24'h000123`, `waitrequest=0`, `readdatavalid` one cycle after accept with data 32'hA1B2C3D4. Required:
  - `flash_mem_address=23'h000123` with `read` high for one cycle.
  - `done_read` pulses once, 3 cycles after the edge.
  - `data_in_read=32'hA1B2C3D4`, `read_error=0`.
- Stall: `waitrequest` high for 4 cycles, then read latency 3. Required:
  - `read` and address held constant for all 5 REQ cycles.
  - `done_read` arrives 9 cycles after the edge.
- Timeout: `TIMEOUT=8`, `readdatavalid` never asserted. Required:
  - `done_read` plus `read_error=1` and `data_in_read=0` after 8 busy cycles.
  - A `readdatavalid` injected 2 cycles later does not change `data_in_read`.
- Ignored start: second rising edge of `start_flag` while `busy=1`. Required: exactly one Avalon read and one `done_read`. A `start_flag` held high after DONE causes no new read.
- Reset mid-read: assert `reset` in WAIT_DATA. Required:
  - All outputs return to their reset values on the next cycle.
  - The subsequent `readdatavalid` is ignored.
  - A fresh read to `24'hFFFFFF` drives `flash_mem_address=23'h7FFFFF`.
